// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: steps two WIDTH-bit operands LSB-first
// through one registered-carry full-adder slice and returns sum/cout.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready, a, b  operand handshake (accepted only in IDLE)
//   out_valid/out_ready      result handshake (held in DONE)
//   sum, cout                WIDTH-bit result and final carry
//   busy                     high while in RUN or DONE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sum_shift;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s1;
  logic             c1;
  logic             s;
  logic             c2;
  logic             cn;
  logic             accept;
  logic             last;

  // Two half-adder cells plus an OR on their carries.
  always_comb begin
    s1 = sa[0] ^ sb[0];
    c1 = sa[0] & sb[0];
    s  = s1 ^ c;
    c2 = s1 & c;
    cn = c1 | c2;
  end

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_w1
    assign sum_shift = s;
  end else begin : g_wn
    assign sum_shift = {s, sum[WIDTH-1:1]};
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        c   <= 1'b0;
        cnt <= '0;
        sum <= '0;
      end else if (state == RUN) begin
        c   <= cn;
        sum <= sum_shift;
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        cnt <= cnt + CW'(1);
        if (last) cout <= cn;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances.
// Each task drives one scenario and checks hand-computed results.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  logic       w1_in_valid;
  logic       w1_in_ready;
  logic [0:0] w1_a;
  logic [0:0] w1_b;
  logic       w1_out_valid;
  logic       w1_out_ready;
  logic [0:0] w1_sum;
  logic       w1_cout;
  logic       w1_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .a         (w1_a),
    .b         (w1_b),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .sum       (w1_sum),
    .cout      (w1_cout),
    .busy      (w1_busy)
  );

  // Accept one operation on the WIDTH=8 instance and count cycles
  // from the accept edge until out_valid is seen (bounded).
  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       output int lat);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op1(input logic x, input logic y, output int lat);
    @(negedge clk);
    w1_a = x;
    w1_b = y;
    w1_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w1_in_valid = 1'b0;
    lat = 0;
    while (!w1_out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    w1_in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, sum, cout} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold rdy=%b ov=%b busy=%b sum=%h cout=%b want 0",
                 in_ready, out_valid, busy, sum, cout);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    w1_in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b want 1 0",
               in_ready, busy);
    end
  endtask

  task automatic test_carry_wrap;
    int lat;
    out_ready = 1'b1;
    do_op(8'hFF, 8'h01, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL latency_ff01 got %0d want 8", lat);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL sum_ff01 got %h/%b want 00/1", sum, cout);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_ff01 ov=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_patterns;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] es [3];
    logic       ec [3];
    int lat;
    va = '{8'h5A, 8'h00, 8'h80};
    vb = '{8'h33, 8'h00, 8'h80};
    es = '{8'h8D, 8'h00, 8'h00};
    ec = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], lat);
      checks++;
      if (lat !== 8 || sum !== es[i] || cout !== ec[i]) begin
        errors++;
        $display("FAIL pattern_%0d lat=%0d sum=%h cout=%b want 8 %h %b",
                 i, lat, sum, cout, es[i], ec[i]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    do_op(8'h5A, 8'h33, lat);
    for (int i = 0; i < 5; i++) begin
      a = 8'h11;
      b = 8'h11;
      in_valid = (i == 2);
      #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 8'h8D || cout !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_%0d ov=%b sum=%h cout=%b rdy=%b want 1 8d 0 0",
                 i, out_valid, sum, cout, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h8D) begin
      errors++;
      $display("FAIL handoff ov=%b rdy=%b sum=%h want 0 1 8d",
               out_valid, in_ready, sum);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sum !== 8'h8D) begin
      errors++;
      $display("FAIL no_accept_during_bp busy=%b sum=%h want 0 8d",
               busy, sum);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    int lat;
    out_ready = 1'b1;
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid busy=%b ov=%b rdy=%b want 0 0 1",
               busy, out_valid, in_ready);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_result out_valid cycles=%0d want 0", seen);
    end
    out_ready = 1'b0;
    do_op(8'h01, 8'h02, lat);
    checks++;
    if (lat !== 8 || sum !== 8'h03 || cout !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op lat=%0d sum=%h cout=%b want 8 03 0",
               lat, sum, cout);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_width1;
    int lat;
    w1_out_ready = 1'b0;
    do_op1(1'b1, 1'b1, lat);
    checks++;
    if (lat !== 1 || w1_sum !== 1'b0 || w1_cout !== 1'b1) begin
      errors++;
      $display("FAIL w1_11 lat=%0d sum=%b cout=%b want 1 0 1",
               lat, w1_sum, w1_cout);
    end
    w1_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w1_out_ready = 1'b0;
    checks++;
    if (w1_out_valid !== 1'b0 || w1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL w1_handoff ov=%b rdy=%b want 0 1",
               w1_out_valid, w1_in_ready);
    end
    do_op1(1'b1, 1'b0, lat);
    checks++;
    if (lat !== 1 || w1_sum !== 1'b1 || w1_cout !== 1'b0) begin
      errors++;
      $display("FAIL w1_10 lat=%0d sum=%b cout=%b want 1 1 0",
               lat, w1_sum, w1_cout);
    end
    w1_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w1_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    w1_in_valid = 1'b0;
    w1_out_ready = 1'b0;
    w1_a = '0;
    w1_b = '0;
    test_reset();
    test_carry_wrap();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer. It accepts two WIDTH-bit operands over a valid/ready handshake and steps them LSB-first through a single full-adder bit slice. The slice is built from two xor/and half-adder cells plus an OR on the carries, with a registered carry. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. The block lets the design reuse one gate-level adder slice instead of instantiating WIDTH parallel adders.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range WIDTH >= 1.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands (high only in IDLE and not in reset).
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result a+b mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: serial add in progress.
  - DONE: out_valid=1.
- IDLE -> RUN on in_valid && in_ready (accept):
  - capture a, b into shift registers sa, sb;
  - clear carry register c;
  - clear bit counter cnt (width clog2(WIDTH), minimum 1);
  - clear sum shift register.
- RUN, each cycle:
  - bit slice: s1=sa[0]^sb[0], c1=sa[0]&sb[0], s=s1^c, c2=s1&c;
  - c <= c1|c2;
  - sum <= {s, sum[WIDTH-1:1]} (shift right, new bit in at MSB);
  - sa, sb shift right by 1;
  - cnt <= cnt+1.
- RUN -> DONE on the cycle cnt==WIDTH-1. In that same edge the last bit is shifted in and cout <= c1|c2.
- DONE -> IDLE on out_ready. sum and cout remain unchanged until the next accept.
- in_valid outside IDLE is ignored; in_ready=0 there, and a, b are not sampled.
- out_ready outside DONE is ignored.
- cout is the registered final carry. The c register keeps running during RUN, but cout updates only on the final RUN edge.
- sum and cout are guaranteed correct only while out_valid=1. Intermediate sum contents during RUN are not specified to consumers.

## Timing
- Reset (rst=1 at a rising edge) forces:
  - state=IDLE;
  - sum=0, cout=0, c=0, cnt=0;
  - out_valid=0, busy=0.
- in_ready is 0 whenever rst=1 (combinational gating) and 1 in the first cycle after reset deasserts.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result. No out_valid is produced for it.
- Latency: accept edge E0; RUN covers edges E1..EW.
  - out_valid rises after edge EW, i.e. WIDTH cycles after accept.
- Output handshake:
  - out_valid stays high, with sum/cout stable, until the edge where out_ready=1.
  - out_valid is low the following cycle and in_ready is high.
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH RUN cycles, DONE, with out_ready high). No accept in the same cycle as result hand-off.
- WIDTH=1: RUN lasts exactly one cycle; cnt==0 is the terminal condition.
- in_ready, out_valid and busy are pure decodes of state (plus rst for in_ready). There is no combinational path from in_valid/out_ready to any output.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0, sum=0, cout=0; in_ready=1 the cycle after release.
- WIDTH=8, a=8'hFF, b=8'h01, out_ready=1 -> out_valid rises exactly 8 cycles after accept, sum=8'h00, cout=1; returns to IDLE next cycle.
- WIDTH=8, a=8'h5A, b=8'h33 -> sum=8'h8D, cout=0. Also a=b=8'h00 -> sum=8'h00, cout=0. Also a=b=8'h80 -> sum=8'h00, cout=1.
- Backpressure: result 8'h8D ready, out_ready low 5 cycles -> out_valid, sum, cout stable all 5 cycles. in_valid pulsed meanwhile with a=8'h11 is not accepted (in_ready=0). The result clears on the out_ready edge.
- Reset mid-operation: assert rst at RUN cycle 4 of a=8'hFF, b=8'hFF -> next cycle IDLE, out_valid never rises. A following a=8'h01, b=8'h02 yields sum=8'h03, cout=0.
- WIDTH=1 build: a=1, b=1 -> out_valid 1 cycle after accept, sum=0, cout=1. Then a=1, b=0 -> sum=1, cout=0.
